// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - gate sensor, card, vacancy and event/barrier signal bundle
`timescale 1ns/1ps
interface parking_gate_controller_if;
  logic entry_sensor;
  logic entry_uni_card;
  logic exit_sensor;
  logic exit_uni_card;
  logic uni_is_vacated_space;
  logic is_vacated_space;
  logic car_entered;
  logic is_uni_car_entered;
  logic car_exited;
  logic is_uni_car_exited;
  logic entry_barrier_open;
  logic exit_barrier_open;
  logic entry_denied;
  logic entry_alarm;
  logic exit_alarm;

  modport master (
    output entry_sensor, entry_uni_card, exit_sensor, exit_uni_card,
    output uni_is_vacated_space, is_vacated_space,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input  entry_barrier_open, exit_barrier_open, entry_denied, entry_alarm, exit_alarm
  );

  modport slave (
    input  entry_sensor, entry_uni_card, exit_sensor, exit_uni_card,
    input  uni_is_vacated_space, is_vacated_space,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output entry_barrier_open, exit_barrier_open, entry_denied, entry_alarm, exit_alarm
  );
endinterface

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - debounced entry/exit gate FSMs with one-event-per-cycle arbiter
`timescale 1ns/1ps
module parking_gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1000,
  parameter int unsigned OPEN_TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned CNT_W               = 32
) (
  input logic clk,
  input logic reset,
  parking_gate_controller_if.slave gate
);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(OPEN_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(OPEN_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {E_IDLE, E_DEB, E_DECIDE, E_REQ, E_OPEN, E_DENY} entry_state_t;
  // X_ALIGN mirrors E_DECIDE so simultaneous vehicles reach REQ on the same cycle.
  typedef enum logic [2:0] {X_IDLE, X_DEB, X_ALIGN, X_REQ, X_OPEN} exit_state_t;

  entry_state_t en_state;
  exit_state_t  ex_state;
  logic [1:0]       entry_sync, exit_sync;
  logic [CNT_W-1:0] en_cnt, en_tmo, ex_cnt, ex_tmo;
  logic             en_cls, ex_cls;
  logic             last_exit;
  logic             entry_s, exit_s;
  logic             entry_req, exit_req, grant_entry, grant_exit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_sync <= 2'b00;
      exit_sync  <= 2'b00;
    end else begin
      entry_sync <= {entry_sync[0], gate.entry_sensor};
      exit_sync  <= {exit_sync[0], gate.exit_sensor};
    end
  end

  assign entry_s = entry_sync[1];
  assign exit_s  = exit_sync[1];

  assign entry_req   = (en_state == E_REQ);
  assign exit_req    = (ex_state == X_REQ);
  assign grant_entry = entry_req & (~exit_req | last_exit);
  assign grant_exit  = exit_req & (~entry_req | ~last_exit);

  // last_exit records only the winner of a real tie, so alternation is between contended grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_exit <= 1'b0;
    end else if (entry_req && exit_req) begin
      last_exit <= ~last_exit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_state                <= E_IDLE;
      en_cnt                  <= '0;
      en_tmo                  <= '0;
      en_cls                  <= 1'b0;
      gate.car_entered        <= 1'b0;
      gate.is_uni_car_entered <= 1'b0;
      gate.entry_barrier_open <= 1'b0;
      gate.entry_denied       <= 1'b0;
      gate.entry_alarm        <= 1'b0;
    end else begin
      gate.car_entered        <= 1'b0;
      gate.is_uni_car_entered <= 1'b0;
      case (en_state)
        E_IDLE: begin
          if (entry_s) begin
            en_state <= E_DEB;
            en_cnt   <= '0;
          end
        end
        E_DEB: begin
          if (!entry_s) begin
            en_state <= E_IDLE;
          end else if (en_cnt == DEB_LAST) begin
            en_state <= E_DECIDE;
            en_cls   <= gate.entry_uni_card;
          end else begin
            en_cnt <= en_cnt + ONE;
          end
        end
        E_DECIDE: begin
          en_cnt <= '0;
          if (en_cls ? gate.uni_is_vacated_space : gate.is_vacated_space) begin
            en_state <= E_REQ;
          end else begin
            en_state          <= E_DENY;
            gate.entry_denied <= 1'b1;
          end
        end
        E_REQ: begin
          if (grant_entry) begin
            en_state                <= E_OPEN;
            en_cnt                  <= '0;
            en_tmo                  <= '0;
            gate.car_entered        <= 1'b1;
            gate.is_uni_car_entered <= en_cls;
            gate.entry_barrier_open <= 1'b1;
          end
        end
        E_OPEN: begin
          if (en_tmo != TMO_MAX) en_tmo <= en_tmo + ONE;
          if (en_tmo == TMO_LAST) gate.entry_alarm <= 1'b1;
          if (entry_s) begin
            en_cnt <= '0;
          end else if (en_cnt == DEB_LAST) begin
            en_state                <= E_IDLE;
            gate.entry_barrier_open <= 1'b0;
          end else begin
            en_cnt <= en_cnt + ONE;
          end
        end
        E_DENY: begin
          if (entry_s) begin
            en_cnt <= '0;
          end else if (en_cnt == DEB_LAST) begin
            en_state          <= E_IDLE;
            gate.entry_denied <= 1'b0;
          end else begin
            en_cnt <= en_cnt + ONE;
          end
        end
        default: en_state <= E_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_state               <= X_IDLE;
      ex_cnt                 <= '0;
      ex_tmo                 <= '0;
      ex_cls                 <= 1'b0;
      gate.car_exited        <= 1'b0;
      gate.is_uni_car_exited <= 1'b0;
      gate.exit_barrier_open <= 1'b0;
      gate.exit_alarm        <= 1'b0;
    end else begin
      gate.car_exited        <= 1'b0;
      gate.is_uni_car_exited <= 1'b0;
      case (ex_state)
        X_IDLE: begin
          if (exit_s) begin
            ex_state <= X_DEB;
            ex_cnt   <= '0;
          end
        end
        X_DEB: begin
          if (!exit_s) begin
            ex_state <= X_IDLE;
          end else if (ex_cnt == DEB_LAST) begin
            ex_state <= X_ALIGN;
            ex_cls   <= gate.exit_uni_card;
          end else begin
            ex_cnt <= ex_cnt + ONE;
          end
        end
        X_ALIGN: begin
          ex_cnt   <= '0;
          ex_state <= X_REQ;
        end
        X_REQ: begin
          if (grant_exit) begin
            ex_state               <= X_OPEN;
            ex_cnt                 <= '0;
            ex_tmo                 <= '0;
            gate.car_exited        <= 1'b1;
            gate.is_uni_car_exited <= ex_cls;
            gate.exit_barrier_open <= 1'b1;
          end
        end
        X_OPEN: begin
          if (ex_tmo != TMO_MAX) ex_tmo <= ex_tmo + ONE;
          if (ex_tmo == TMO_LAST) gate.exit_alarm <= 1'b1;
          if (exit_s) begin
            ex_cnt <= '0;
          end else if (ex_cnt == DEB_LAST) begin
            ex_state               <= X_IDLE;
            gate.exit_barrier_open <= 1'b0;
          end else begin
            ex_cnt <= ex_cnt + ONE;
          end
        end
        default: ex_state <= X_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - scoreboard bench for parking_gate_controller
`timescale 1ns/1ps
module tb_parking_gate_controller;
  localparam int D = 4;
  localparam int T = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  parking_gate_controller_if g();

  parking_gate_controller #(.DEBOUNCE_CYCLES(D), .OPEN_TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .gate(g)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef logic [33:0] ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e, o;
  bit overlap, leak;
  int n_checks = 0;
  int n_pass = 0;
  int b, b2;

  always @(negedge clk) begin
    if (g.car_entered) obs_q.push_back({1'b0, g.is_uni_car_entered, 32'(edge_cnt)});
    if (g.car_exited)  obs_q.push_back({1'b1, g.is_uni_car_exited, 32'(edge_cnt)});
    if (g.car_entered && g.car_exited) overlap = 1'b1;
    if ((g.is_uni_car_entered && !g.car_entered) || (g.is_uni_car_exited && !g.car_exited)) leak = 1'b1;
  end

  function automatic ev_t ev(input bit is_exit, input bit uni, input int at);
    return {is_exit, uni, 32'(at)};
  endfunction

  function automatic logic [8:0] outs();
    return {g.car_entered, g.is_uni_car_entered, g.car_exited, g.is_uni_car_exited,
            g.entry_barrier_open, g.exit_barrier_open, g.entry_denied, g.entry_alarm, g.exit_alarm};
  endfunction

  task automatic wait_edge(input int t);
    while (edge_cnt < t) @(negedge clk);
  endtask

  task automatic apply_reset();
    g.entry_sensor = 0; g.entry_uni_card = 0; g.exit_sensor = 0; g.exit_uni_card = 0;
    g.uni_is_vacated_space = 0; g.is_vacated_space = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    overlap = 1'b0; leak = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (outs() !== 9'd0) $display("FAIL reset_outs got=%b want=0", outs()); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (outs() !== 9'd0) $display("FAIL reset_idle got=%b want=0", outs()); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL reset_events got=%0d want=0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_uni_entry();
    apply_reset();
    g.entry_uni_card = 1; g.uni_is_vacated_space = 1; g.entry_sensor = 1;
    b = edge_cnt;
    exp_q.push_back(ev(0, 1, b + D + 5));
    wait_edge(b + D + 4);
    n_checks++; if (g.entry_barrier_open !== 1'b0) $display("FAIL t1_pre got=%b want=0", g.entry_barrier_open); else n_pass++;
    g.uni_is_vacated_space = 0;
    wait_edge(b + D + 5);
    n_checks++; if (g.entry_barrier_open !== 1'b1) $display("FAIL t1_open got=%b want=1", g.entry_barrier_open); else n_pass++;
    wait_edge(b + 12);
    g.entry_sensor = 0;
    wait_edge(b + 13 + D);
    n_checks++; if (g.entry_barrier_open !== 1'b1) $display("FAIL t1_hold got=%b want=1", g.entry_barrier_open); else n_pass++;
    wait_edge(b + 14 + D);
    n_checks++; if (g.entry_barrier_open !== 1'b0) $display("FAIL t1_close got=%b want=0", g.entry_barrier_open); else n_pass++;
    n_checks++; if (g.entry_alarm !== 1'b0) $display("FAIL t1_alarm got=%b want=0", g.entry_alarm); else n_pass++;
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      n_checks++; if (o !== e) $display("FAIL t1_event got=%h want=%h", o, e); else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL t1_extra got=%0d want=0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_deny();
    apply_reset();
    g.entry_uni_card = 0; g.is_vacated_space = 0; g.uni_is_vacated_space = 1; g.entry_sensor = 1;
    b = edge_cnt;
    wait_edge(b + D + 3);
    n_checks++; if (g.entry_denied !== 1'b0) $display("FAIL t2_pre got=%b want=0", g.entry_denied); else n_pass++;
    wait_edge(b + D + 4);
    n_checks++; if (g.entry_denied !== 1'b1) $display("FAIL t2_denied got=%b want=1", g.entry_denied); else n_pass++;
    wait_edge(b + 12);
    n_checks++; if (g.entry_barrier_open !== 1'b0) $display("FAIL t2_barrier got=%b want=0", g.entry_barrier_open); else n_pass++;
    g.entry_sensor = 0;
    wait_edge(b + 13 + D);
    n_checks++; if (g.entry_denied !== 1'b1) $display("FAIL t2_hold got=%b want=1", g.entry_denied); else n_pass++;
    wait_edge(b + 14 + D);
    n_checks++; if (g.entry_denied !== 1'b0) $display("FAIL t2_clear got=%b want=0", g.entry_denied); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL t2_events got=%0d want=0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_tie();
    apply_reset();
    g.is_vacated_space = 1; g.uni_is_vacated_space = 1;
    g.entry_uni_card = 0; g.exit_uni_card = 1;
    g.entry_sensor = 1; g.exit_sensor = 1;
    b = edge_cnt;
    exp_q.push_back(ev(1, 1, b + D + 5));
    exp_q.push_back(ev(0, 0, b + D + 6));
    wait_edge(b + 12);
    g.entry_sensor = 0; g.exit_sensor = 0;
    wait_edge(b + 22);
    g.entry_uni_card = 1; g.exit_uni_card = 0;
    g.entry_sensor = 1; g.exit_sensor = 1;
    b2 = edge_cnt;
    exp_q.push_back(ev(0, 1, b2 + D + 5));
    exp_q.push_back(ev(1, 0, b2 + D + 6));
    wait_edge(b2 + 12);
    g.entry_sensor = 0; g.exit_sensor = 0;
    wait_edge(b2 + 22);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      n_checks++; if (o !== e) $display("FAIL t3_event got=%h want=%h", o, e); else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL t3_extra got=%0d want=0", obs_q.size()); else n_pass++;
    n_checks++; if (overlap !== 1'b0) $display("FAIL t3_overlap got=%b want=0", overlap); else n_pass++;
    n_checks++; if (leak !== 1'b0) $display("FAIL t3_class_leak got=%b want=0", leak); else n_pass++;
  endtask

  task automatic test_glitch();
    apply_reset();
    g.is_vacated_space = 1; g.entry_uni_card = 0; g.entry_sensor = 1;
    b = edge_cnt;
    wait_edge(b + D - 1);
    g.entry_sensor = 0;
    wait_edge(b + 15);
    n_checks++; if (outs() !== 9'd0) $display("FAIL t4_outs got=%b want=0", outs()); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL t4_events got=%0d want=0", obs_q.size()); else n_pass++;
    g.entry_sensor = 1;
    b2 = edge_cnt;
    exp_q.push_back(ev(0, 0, b2 + D + 5));
    wait_edge(b2 + D + 5);
    n_checks++; if (g.entry_barrier_open !== 1'b1) $display("FAIL t4_fresh_open got=%b want=1", g.entry_barrier_open); else n_pass++;
    g.entry_sensor = 0;
    wait_edge(b2 + 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      n_checks++; if (o !== e) $display("FAIL t4_event got=%h want=%h", o, e); else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL t4_extra got=%0d want=0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    apply_reset();
    g.exit_uni_card = 0; g.exit_sensor = 1;
    b = edge_cnt;
    exp_q.push_back(ev(1, 0, b + D + 5));
    wait_edge(b + D + 4 + T);
    n_checks++; if (g.exit_alarm !== 1'b0) $display("FAIL t5_pre got=%b want=0", g.exit_alarm); else n_pass++;
    wait_edge(b + D + 5 + T);
    n_checks++; if (g.exit_alarm !== 1'b1) $display("FAIL t5_alarm got=%b want=1", g.exit_alarm); else n_pass++;
    n_checks++; if (g.exit_barrier_open !== 1'b1) $display("FAIL t5_open got=%b want=1", g.exit_barrier_open); else n_pass++;
    wait_edge(b + 40);
    n_checks++; if (g.exit_barrier_open !== 1'b1) $display("FAIL t5_still_open got=%b want=1", g.exit_barrier_open); else n_pass++;
    g.exit_sensor = 0;
    wait_edge(b + 42 + D);
    n_checks++; if (g.exit_barrier_open !== 1'b0) $display("FAIL t5_close got=%b want=0", g.exit_barrier_open); else n_pass++;
    n_checks++; if (g.exit_alarm !== 1'b1) $display("FAIL t5_sticky got=%b want=1", g.exit_alarm); else n_pass++;
    n_checks++; if (g.entry_alarm !== 1'b0) $display("FAIL t5_entry_alarm got=%b want=0", g.entry_alarm); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      n_checks++; if (o !== e) $display("FAIL t5_event got=%h want=%h", o, e); else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL t5_extra got=%0d want=0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    g.exit_uni_card = 0; g.exit_sensor = 1;
    b = edge_cnt;
    exp_q.push_back(ev(1, 0, b + D + 5));
    wait_edge(b + 2);
    g.entry_uni_card = 1; g.uni_is_vacated_space = 1; g.entry_sensor = 1;
    wait_edge(b + D + 6);
    n_checks++; if (g.exit_barrier_open !== 1'b1) $display("FAIL t6_pre_open got=%b want=1", g.exit_barrier_open); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (outs() !== 9'd0) $display("FAIL t6_reset_outs got=%b want=0", outs()); else n_pass++;
    g.entry_sensor = 0; g.exit_sensor = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      n_checks++; if (o !== e) $display("FAIL t6_event got=%h want=%h", o, e); else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL t6_dropped_req got=%0d want=0", obs_q.size()); else n_pass++;
    g.entry_sensor = 1;
    b2 = edge_cnt;
    exp_q.push_back(ev(0, 1, b2 + D + 5));
    wait_edge(b2 + D + 4);
    n_checks++; if (g.entry_barrier_open !== 1'b0) $display("FAIL t6_fresh_pre got=%b want=0", g.entry_barrier_open); else n_pass++;
    wait_edge(b2 + D + 5);
    n_checks++; if (g.entry_barrier_open !== 1'b1) $display("FAIL t6_fresh_open got=%b want=1", g.entry_barrier_open); else n_pass++;
    g.entry_sensor = 0;
    wait_edge(b2 + 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      n_checks++; if (o !== e) $display("FAIL t6_fresh_event got=%h want=%h", o, e); else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL t6_extra got=%0d want=0", obs_q.size()); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_uni_entry();
    test_deny();
    test_tie();
    test_glitch();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
